// File: rtl/icache_pkg.sv
// Shared constants and width helpers for the set-associative instruction cache.
// FSM encodings, AXI response codes and address-field width functions.
package icache_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   function automatic int word_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int index_w(input int sets);
      return $clog2(sets);
   endfunction

   // Byte offset (2 bits) plus word and index fields leave the tag.
   function automatic int tag_w(input int line_words, input int sets);
      return 30 - word_w(line_words) - index_w(sets);
   endfunction

   function automatic int at_least_one(input int w);
      return (w > 0) ? w : 1;
   endfunction

   function automatic logic resp_is_err(input logic [1:0] resp);
      case (resp)
         RESP_OKAY, RESP_EXOKAY:   return 1'b0;
         RESP_SLVERR, RESP_DECERR: return 1'b1;
         default:                  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: tag, valid and data storage with
// combinational read, per-word data write, tag+valid write and flush-all.
module icache_way
   import icache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 3,
   parameter int WRD_W      = 2,
   parameter int TAG_W      = 25
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [WRD_W-1:0]  rd_word,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic              data_we,
   input  logic [WRD_W-1:0]  wr_word,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              line_we,
   input  logic              line_valid,
   input  logic [TAG_W-1:0]  wr_tag
);

   logic [SETS-1:0]   valid_reg;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [DATA_W-1:0] data_mem [SETS][LINE_WORDS];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_reg <= '0;
      end else if (flush) begin
         valid_reg <= '0;
      end else if (line_we) begin
         valid_reg[wr_index] <= line_valid;
      end
   end

   // Storage arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clock) begin
      if (line_we) begin
         tag_mem[wr_index] <= wr_tag;
      end
      if (data_we) begin
         data_mem[wr_index][wr_word] <= wr_data;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: same-cycle hits, one INCR burst per miss,
// uncached window, round-robin replacement, fence.i flush and refill faults.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int          WAYS       = 2,
   parameter int          SETS       = 8,
   parameter int          LINE_WORDS = 4,
   parameter logic [31:0] UC_BASE    = 32'h0f00_0000,
   parameter logic [31:0] UC_LIMIT   = 32'h0f00_2000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rreq_i,
   input  logic [31:0] raddr_i,
   input  logic        flush_i,
   output logic        rready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        fault_o,
   output logic        icache_arvalid_o,
   input  logic        icache_arready_i,
   output logic [31:0] icache_araddr_o,
   output logic [7:0]  icache_arlen_o,
   input  logic        icache_rvalid_i,
   output logic        icache_rready_o,
   input  logic [31:0] icache_rdata_i,
   input  logic [1:0]  icache_rresp_i,
   input  logic        icache_rlast_i
);

   localparam int WB  = word_w(LINE_WORDS);
   localparam int WW  = at_least_one(WB);
   localparam int IB  = index_w(SETS);
   localparam int TW  = tag_w(LINE_WORDS, SETS);
   localparam int WYB = at_least_one($clog2(WAYS));

   logic [1:0]     state_reg;
   logic [31:0]    addr_reg;
   logic           uc_reg;
   logic [WYB-1:0] victim_reg;
   logic [WW-1:0]  beat_reg;
   logic           err_reg;
   logic           flush_pend_reg;
   logic [WYB-1:0] rr_ptr_reg [SETS];

   logic [WW-1:0]     req_word, cap_word;
   logic [IB-1:0]     req_index, cap_index, wr_index;
   logic [TW-1:0]     req_tag, cap_tag;
   logic [31:0]       req_addr, line_base;
   logic              req_uc;

   logic [WAYS-1:0]   way_valid;
   logic [TW-1:0]     way_tag  [WAYS];
   logic [DATA_W-1:0] way_data [WAYS];
   logic [WAYS-1:0]   hit_vec;
   logic [DATA_W-1:0] hit_data;
   logic [WYB-1:0]    victim_pick, tgt_way;
   logic              found;

   logic is_idle, flush_now, accept, hit, miss;
   logic beat, beat_err, last, err_any, fill_ok, beat_hit;
   logic data_we_all, line_we_all;

   // Address field split for the live request and the captured miss.
   assign req_addr  = raddr_i & ~32'h3;
   assign req_word  = WW'((raddr_i >> 2) & 32'(LINE_WORDS - 1));
   assign req_index = IB'(raddr_i >> (2 + WB));
   assign req_tag   = TW'(raddr_i >> (2 + WB + IB));
   assign req_uc    = (req_addr >= UC_BASE) && (req_addr <= UC_LIMIT);

   assign cap_word  = WW'((addr_reg >> 2) & 32'(LINE_WORDS - 1));
   assign cap_index = IB'(addr_reg >> (2 + WB));
   assign cap_tag   = TW'(addr_reg >> (2 + WB + IB));
   assign line_base = addr_reg & ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

   assign is_idle   = (state_reg == ST_IDLE);
   assign flush_now = is_idle && (flush_i || flush_pend_reg);
   assign rready_o  = is_idle && !flush_now;
   assign accept    = rready_o && rreq_i;
   assign hit       = accept && (|hit_vec);
   assign miss      = accept && !(|hit_vec);

   assign beat     = (state_reg == ST_FILL) && icache_rvalid_i;
   assign beat_err = beat && resp_is_err(icache_rresp_i);
   assign last     = beat && icache_rlast_i;
   assign err_any  = err_reg || beat_err;
   assign fill_ok  = last && !err_any && !uc_reg;
   assign beat_hit = beat && !beat_err && (uc_reg || (beat_reg == cap_word));

   // The victim is invalidated at miss time so a partially overwritten line
   // can never hit; it becomes valid again only on an error-free rlast.
   assign data_we_all = beat && !uc_reg;
   assign line_we_all = (miss && !req_uc) || (last && !uc_reg);
   assign tgt_way     = is_idle ? victim_pick : victim_reg;
   assign wr_index    = is_idle ? req_index : cap_index;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .IDX_W      (IB),
            .WRD_W      (WW),
            .TAG_W      (TW)
         ) u_way (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush_now),
            .rd_index   (req_index),
            .rd_word    (req_word),
            .rd_tag     (way_tag[gi]),
            .rd_valid   (way_valid[gi]),
            .rd_data    (way_data[gi]),
            .wr_index   (wr_index),
            .data_we    (data_we_all && (tgt_way == WYB'(gi))),
            .wr_word    (beat_reg),
            .wr_data    (icache_rdata_i),
            .line_we    (line_we_all && (tgt_way == WYB'(gi))),
            .line_valid (fill_ok),
            .wr_tag     (cap_tag)
         );
         assign hit_vec[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
      end
   endgenerate

   always_comb begin
      hit_data = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) begin
            hit_data = hit_data | way_data[w];
         end
      end
   end

   // Lowest invalid way first, otherwise the set's round-robin pointer.
   always_comb begin
      victim_pick = rr_ptr_reg[req_index];
      found       = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !way_valid[w]) begin
            victim_pick = WYB'(w);
            found       = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         addr_reg       <= '0;
         uc_reg         <= 1'b0;
         victim_reg     <= '0;
         beat_reg       <= '0;
         err_reg        <= 1'b0;
         flush_pend_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (flush_now) begin
                  flush_pend_reg <= 1'b0;
               end else if (miss) begin
                  addr_reg   <= req_addr;
                  uc_reg     <= req_uc;
                  victim_reg <= victim_pick;
                  beat_reg   <= '0;
                  err_reg    <= 1'b0;
                  state_reg  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (flush_i) begin
                  flush_pend_reg <= 1'b1;
               end
               if (icache_arready_i) begin
                  state_reg <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (flush_i) begin
                  flush_pend_reg <= 1'b1;
               end
               if (beat) begin
                  beat_reg <= (LINE_WORDS == 1) ? '0 : beat_reg + 1'b1;
                  if (beat_err) begin
                     err_reg <= 1'b1;
                  end
                  if (icache_rlast_i) begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            rr_ptr_reg[s] <= '0;
         end
      end else if (flush_now) begin
         for (int s = 0; s < SETS; s++) begin
            rr_ptr_reg[s] <= '0;
         end
      end else if (fill_ok) begin
         rr_ptr_reg[cap_index] <= (WAYS == 1) ? '0 : rr_ptr_reg[cap_index] + 1'b1;
      end
   end

   assign rvalid_o = hit || beat_hit;
   assign rdata_o  = hit ? hit_data : (beat_hit ? icache_rdata_i : 32'd0);
   assign fault_o  = last && err_any;

   assign icache_arvalid_o = (state_reg == ST_SEND);
   assign icache_araddr_o  = (state_reg != ST_SEND) ? 32'd0 : (uc_reg ? addr_reg : line_base);
   assign icache_arlen_o   = ((state_reg == ST_SEND) && !uc_reg) ? 8'(LINE_WORDS - 1) : 8'd0;
   assign icache_rready_o  = (state_reg == ST_FILL);

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default parameters: fills, hits, conflicts,
// uncached window, refill errors, flushes and reset during a burst.
module tb_icache_assoc;

   localparam logic [31:0] UC_BASE_TB  = 32'h0f00_0000;
   localparam logic [31:0] UC_LIMIT_TB = 32'h0f00_2000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rreq_i, flush_i;
   logic [31:0] raddr_i;
   logic        rready_o, rvalid_o, fault_o;
   logic [31:0] rdata_o;
   logic        icache_arvalid_o, icache_arready_i;
   logic [31:0] icache_araddr_o;
   logic [7:0]  icache_arlen_o;
   logic        icache_rvalid_i, icache_rready_o, icache_rlast_i;
   logic [31:0] icache_rdata_i;
   logic [1:0]  icache_rresp_i;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clock = ~clock;

   icache_assoc dut (
      .clock            (clock),
      .reset            (reset),
      .rreq_i           (rreq_i),
      .raddr_i          (raddr_i),
      .flush_i          (flush_i),
      .rready_o         (rready_o),
      .rvalid_o         (rvalid_o),
      .rdata_o          (rdata_o),
      .fault_o          (fault_o),
      .icache_arvalid_o (icache_arvalid_o),
      .icache_arready_i (icache_arready_i),
      .icache_araddr_o  (icache_araddr_o),
      .icache_arlen_o   (icache_arlen_o),
      .icache_rvalid_i  (icache_rvalid_i),
      .icache_rready_o  (icache_rready_o),
      .icache_rdata_i   (icache_rdata_i),
      .icache_rresp_i   (icache_rresp_i),
      .icache_rlast_i   (icache_rlast_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5a5a_c3c3;
   endfunction

   task automatic check_reset_outputs(input string where);
      check_eq({where, "_rready"},  32'(rready_o), 32'd1);
      check_eq({where, "_rvalid"},  32'(rvalid_o), 32'd0);
      check_eq({where, "_rdata"},   rdata_o, 32'd0);
      check_eq({where, "_fault"},   32'(fault_o), 32'd0);
      check_eq({where, "_arvalid"}, 32'(icache_arvalid_o), 32'd0);
      check_eq({where, "_araddr"},  icache_araddr_o, 32'd0);
      check_eq({where, "_arlen"},   32'(icache_arlen_o), 32'd0);
      check_eq({where, "_axrready"}, 32'(icache_rready_o), 32'd0);
   endtask

   task automatic expect_hit(input logic [31:0] addr);
      $display("[TB] hit   %08h expect data %08h", addr, mem_word(addr));
      rreq_i = 1'b1;
      raddr_i = addr;
      #1;
      check_eq("hit_rvalid", 32'(rvalid_o), 32'd1);
      check_eq("hit_rdata", rdata_o, mem_word(addr));
      @(posedge clock);
      @(negedge clock);
      rreq_i = 1'b0;
      #1;
      check_eq("hit_no_refill", 32'(icache_arvalid_o), 32'd0);
   endtask

   // Full miss: request, address phase (one stall cycle), beats, return to idle.
   task automatic miss_fill(input logic [31:0] addr, input int err_beat, input int flush_beat);
      logic        uc;
      logic [31:0] base;
      int          len;
      int          want;
      logic        exp_rv;
      uc   = (addr >= UC_BASE_TB) && (addr <= UC_LIMIT_TB);
      base = uc ? addr : (addr & 32'hffff_fff0);
      len  = uc ? 0 : 3;
      want = uc ? 0 : int'((addr >> 2) & 32'h3);
      $display("[TB] miss  %08h burst %08h len %0d err_beat %0d flush_beat %0d",
               addr, base, len, err_beat, flush_beat);
      rreq_i = 1'b1;
      raddr_i = addr;
      #1;
      check_eq("miss_rready", 32'(rready_o), 32'd1);
      check_eq("miss_no_rvalid", 32'(rvalid_o), 32'd0);
      @(posedge clock);
      @(negedge clock);
      rreq_i = 1'b0;
      raddr_i = 32'hdead_beec;
      #1;
      check_eq("send_arvalid", 32'(icache_arvalid_o), 32'd1);
      check_eq("send_araddr", icache_araddr_o, base);
      check_eq("send_arlen", 32'(icache_arlen_o), 32'(len));
      check_eq("send_rready", 32'(rready_o), 32'd0);
      @(posedge clock);
      @(negedge clock);
      icache_arready_i = 1'b1;
      #1;
      check_eq("send_arvalid_held", 32'(icache_arvalid_o), 32'd1);
      check_eq("send_araddr_held", icache_araddr_o, base);
      @(posedge clock);
      @(negedge clock);
      icache_arready_i = 1'b0;
      for (int b = 0; b <= len; b++) begin
         icache_rvalid_i = 1'b1;
         icache_rdata_i  = mem_word(base + 32'(4 * b));
         icache_rresp_i  = (b == err_beat) ? 2'd2 : 2'd0;
         icache_rlast_i  = (b == len);
         flush_i         = (b == flush_beat);
         exp_rv          = (b == want) && (b != err_beat);
         #1;
         check_eq("fill_axrready", 32'(icache_rready_o), 32'd1);
         check_eq("fill_rvalid", 32'(rvalid_o), 32'(exp_rv));
         if (exp_rv) check_eq("fill_rdata", rdata_o, mem_word(base + 32'(4 * b)));
         if (b == len) check_eq("fill_fault", 32'(fault_o), 32'(err_beat >= 0));
         @(posedge clock);
         @(negedge clock);
      end
      icache_rvalid_i = 1'b0;
      icache_rlast_i  = 1'b0;
      icache_rresp_i  = 2'd0;
      flush_i         = 1'b0;
      #1;
      check_eq("post_fault", 32'(fault_o), 32'd0);
      check_eq("post_rready", 32'(rready_o), 32'(flush_beat < 0));
      if (flush_beat >= 0) begin
         @(posedge clock);
         @(negedge clock);
         #1;
         check_eq("post_flush_rready", 32'(rready_o), 32'd1);
      end
   endtask

   initial begin
      rreq_i = 1'b0;
      raddr_i = 32'd0;
      flush_i = 1'b0;
      icache_arready_i = 1'b0;
      icache_rvalid_i = 1'b0;
      icache_rdata_i = 32'd0;
      icache_rresp_i = 2'd0;
      icache_rlast_i = 1'b0;
      #2;
      $display("[TB] reset values");
      check_reset_outputs("rst");
      @(negedge clock);
      reset = 1'b0;

      // Cold miss, then same-cycle hit on another word of the line
      miss_fill(32'h8000_0004, -1, -1);
      expect_hit(32'h8000_000c);

      // Conflict in set 0: third line evicts way 0
      miss_fill(32'h8000_0080, -1, -1);
      expect_hit(32'h8000_0000);
      expect_hit(32'h8000_0084);
      miss_fill(32'h8000_0100, -1, -1);
      expect_hit(32'h8000_0088);
      expect_hit(32'h8000_0104);
      miss_fill(32'h8000_0000, -1, -1);

      // Uncached window: exact address, single beat, never allocated
      miss_fill(32'h0f00_1000, -1, -1);
      miss_fill(32'h0f00_1000, -1, -1);
      miss_fill(32'h0f00_2000, -1, -1);

      // Refill errors: other beat and the requested beat itself
      miss_fill(32'h8000_0204, 2, -1);
      miss_fill(32'h8000_0204, -1, -1);
      expect_hit(32'h8000_0208);
      miss_fill(32'h8000_0308, 2, -1);
      miss_fill(32'h8000_0308, -1, -1);

      // Flush in idle: request in the flush cycle is ignored, line then misses
      miss_fill(32'h8000_0410, -1, -1);
      expect_hit(32'h8000_0414);
      $display("[TB] flush in idle");
      flush_i = 1'b1;
      rreq_i = 1'b1;
      raddr_i = 32'h8000_0414;
      #1;
      check_eq("flush_rready", 32'(rready_o), 32'd0);
      check_eq("flush_rvalid", 32'(rvalid_o), 32'd0);
      @(posedge clock);
      @(negedge clock);
      flush_i = 1'b0;
      rreq_i = 1'b0;
      #1;
      check_eq("flush_req_ignored", 32'(icache_arvalid_o), 32'd0);
      miss_fill(32'h8000_0414, -1, -1);

      // Flush during fill: filled line must not survive
      miss_fill(32'h8000_0520, -1, 0);
      miss_fill(32'h8000_0524, -1, -1);

      // Reset on beat 1 of a refill
      $display("[TB] reset during refill of 80000644");
      rreq_i = 1'b1;
      raddr_i = 32'h8000_0644;
      @(posedge clock);
      @(negedge clock);
      rreq_i = 1'b0;
      icache_arready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      icache_arready_i = 1'b0;
      icache_rvalid_i = 1'b1;
      icache_rdata_i = mem_word(32'h8000_0640);
      @(posedge clock);
      @(negedge clock);
      icache_rdata_i = mem_word(32'h8000_0644);
      #1;
      check_eq("abort_beat1_rvalid", 32'(rvalid_o), 32'd1);
      reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      @(negedge clock);
      reset = 1'b0;
      for (int b = 2; b <= 3; b++) begin
         icache_rdata_i = mem_word(32'h8000_0640 + 32'(4 * b));
         icache_rlast_i = (b == 3);
         #1;
         check_eq("abort_axrready", 32'(icache_rready_o), 32'd0);
         check_eq("abort_rvalid", 32'(rvalid_o), 32'd0);
         @(posedge clock);
         @(negedge clock);
      end
      icache_rvalid_i = 1'b0;
      icache_rlast_i = 1'b0;
      miss_fill(32'h8000_0644, -1, -1);
      expect_hit(32'h8000_064c);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
